alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 71 +++++++
 tb/tb_alu_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command, result and external-ALU signal bundle for alu_sequencer.
// slave faces the sequencer; master faces the command source, the consumer and the ALU.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_n;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_s;
  logic [7:0] alu_o;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_n, alu_o, res_ready,
    output cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_zero
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_n, alu_o, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Drives an external combinational ALU from registered operands, iterating the
// shift/rotate ops cmd_n+1 times, and returns the accumulator with a ready/valid handshake.
module alu_sequencer (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] breg_q, breg_d;
  logic [2:0] opreg_q, opreg_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      breg_q  <= 8'h00;
      opreg_q <= 3'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      breg_q  <= breg_d;
      opreg_q <= opreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    breg_d  = breg_q;
    opreg_d = opreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          acc_d   = bus.cmd_a;
          breg_d  = bus.cmd_b;
          opreg_d = bus.cmd_op;
          // Only shift/rotate ops (msb of opcode set) repeat.
          cnt_d   = bus.cmd_op[2] ? bus.cmd_n : 3'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d = bus.alu_o;
        if (cnt_q == 3'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from registers; no cmd_* to alu_* path.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = breg_q;
  assign bus.alu_s     = opreg_q;
  assign bus.res_data  = acc_q;
  assign bus.res_zero  = (acc_q == 8'h00);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized checks of alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [7:0] seq [16];
  int   seq_n;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU (environment, single-step shifts/rotates).
  always_comb begin
    bus.alu_o = 8'h00;
    case (bus.alu_s)
      3'd0: bus.alu_o = bus.alu_a + bus.alu_b;
      3'd1: bus.alu_o = bus.alu_a - bus.alu_b;
      3'd2: bus.alu_o = bus.alu_a | bus.alu_b;
      3'd3: bus.alu_o = bus.alu_a & bus.alu_b;
      3'd4: bus.alu_o = {bus.alu_a[6:0], 1'b0};
      3'd5: bus.alu_o = {1'b0, bus.alu_a[7:1]};
      3'd6: bus.alu_o = {bus.alu_a[6:0], bus.alu_a[7]};
      default: bus.alu_o = {bus.alu_a[0], bus.alu_a[7:1]};
    endcase
  end

  function automatic int ref_result(int op, int a, int b, int n);
    int acc;
    acc = a;
    case (op)
      0: acc = (a + b) % 256;
      1: acc = (a - b + 256) % 256;
      2: acc = a | b;
      3: acc = a & b;
      default:
        for (int i = 0; i <= n; i++) begin
          case (op)
            4: acc = (acc * 2) % 256;
            5: acc = acc / 2;
            6: acc = (acc * 2) % 256 + acc / 128;
            default: acc = acc / 2 + (acc % 2) * 128;
          endcase
        end
    endcase
    return acc;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 3'($urandom);
    bus.cmd_a     = 8'($urandom);
    bus.cmd_b     = 8'($urandom);
    bus.cmd_n     = 3'($urandom);
  endtask

  task automatic issue(input int op, input int a, input int b, input int n);
    chk("cmd_ready_idle", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_a     = 8'(a);
    bus.cmd_b     = 8'(b);
    bus.cmd_n     = 3'(n);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Issue one command, check latency/result/hold behaviour, then drain it.
  task automatic run(input int op, input int a, input int b, input int n,
                     input int exp, input int hold, input bit nz);
    int lat;
    issue(op, a, b, n);
    lat = 0;
    seq_n = 0;
    while (!bus.res_valid && lat < 20) begin
      if (seq_n < 16) begin
        seq[seq_n] = bus.alu_a;
        seq_n++;
      end
      if (nz) noise();
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (op < 4) ? 1 : n + 1);
    chk("res_data", int'(bus.res_data), exp);
    chk("res_zero", int'(bus.res_zero), (exp == 0) ? 1 : 0);
    chk("alu_b_held", int'(bus.alu_b), b);
    chk("alu_s_held", int'(bus.alu_s), op);
    for (int i = 0; i < hold; i++) begin
      bus.res_ready = 1'b0;
      if (nz) noise();
      @(posedge clk); #1;
      chk("hold_valid", int'(bus.res_valid), 1);
      chk("hold_data", int'(bus.res_data), exp);
      chk("hold_cmd_ready", int'(bus.cmd_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("drain_cmd_ready", int'(bus.cmd_ready), 1);
    chk("drain_res_valid", int'(bus.res_valid), 0);
  endtask

  initial begin
    int op, a, b, n, bad;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_n     = 3'd0;
    bus.res_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_res_zero", int'(bus.res_zero), 1);
    chk("rst_alu_a", int'(bus.alu_a), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1'b0);
    run(1, 8'h05, 8'h05, 0, 8'h00, 0, 1'b0);
    run(1, 8'h00, 8'h01, 0, 8'hFF, 0, 1'b0);
    run(6, 8'h81, 8'h00, 3, 8'h18, 0, 1'b0);
    chk("rol_seq0", int'(seq[0]), 8'h81);
    chk("rol_seq1", int'(seq[1]), 8'h03);
    chk("rol_seq2", int'(seq[2]), 8'h06);
    chk("rol_seq3", int'(seq[3]), 8'h0C);
    run(5, 8'hF0, 8'h00, 7, 8'h00, 0, 1'b0);
    run(2, 8'h3C, 8'hA5, 5, 8'hBD, 5, 1'b1);
    run(7, 8'h01, 8'h00, 0, 8'h80, 0, 1'b0);

    // Reset asserted asynchronously in the third EXEC cycle.
    issue(4, 8'h01, 8'h00, 7);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("mid_rst_res_valid", int'(bus.res_valid), 0);
    chk("mid_rst_res_data", int'(bus.res_data), 0);
    chk("mid_rst_res_zero", int'(bus.res_zero), 1);
    chk("mid_rst_alu_a", int'(bus.alu_a), 0);
    chk("mid_rst_alu_s", int'(bus.alu_s), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b0) bad++;
    end
    chk("aborted_no_result", bad, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    run(0, 8'hFF, 8'h01, 3, 8'h00, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      n  = int'($urandom_range(0, 7));
      run(op, a, b, n, ref_result(op, a, b, n), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
